// File: rtl/des_key_schedule.sv
// DES key schedule: emits the 16 round subkeys (K1..K16, or K16..K1 for decrypt) over a valid/ready handshake.
// Optional key parity checking is compiled in with `define DES_KEY_PARITY_CHECK_EN (adds the parity_err output).
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic [47:0] round_key,
    output logic        round_key_valid,
    input  logic        round_key_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    output logic        parity_err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        dec_q, dec_d;
    logic [3:0]  idx_q, idx_d;
    logic [47:0] rk_q, rk_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [55:0] pc1_key;
    logic [55:0] cd_sel;
    logic [47:0] pc2_out;
    logic [7:0]  key_lsb_unused;
    logic [27:0] c_base, d_base, c_sel, d_sel;
    logic [3:0]  idx_next;
    logic        accept, dir_left, single, no_shift;

    // Bit n of the DES numbering lives at key_in[64-n] / cd[56-n] / round_key[48-n].
    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
        assign pc1_key[55-gi] = key_in[64-PC1_TBL[gi]];
    end

    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
        assign pc2_out[47-gi] = cd_sel[56-PC2_TBL[gi]];
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    logic [7:0] byte_even;
    logic       parity_q, parity_d;
`endif

    for (genvar gi = 0; gi < 8; gi++) begin : g_byte
        assign key_lsb_unused[gi] = key_in[8*gi];
`ifdef DES_KEY_PARITY_CHECK_EN
        assign byte_even[gi] = ~^key_in[8*gi +: 8];
`endif
    end

    // C/D always hold the pair belonging to the subkey currently presented, so
    // both acceptance and advance share one rotate-then-PC2 path.
    always_comb begin
        accept   = (state_q == S_IDLE) && start;
        idx_next = accept ? 4'd0 : idx_q + 4'd1;
        dir_left = accept ? ~decrypt : ~dec_q;
        c_base   = accept ? pc1_key[55:28] : c_q;
        d_base   = accept ? pc1_key[27:0]  : d_q;
        single   = (idx_next == 4'd0) || (idx_next == 4'd1) ||
                   (idx_next == 4'd8) || (idx_next == 4'd15);
        no_shift = ~dir_left && (idx_next == 4'd0);
        if (no_shift) begin
            c_sel = c_base;
            d_sel = d_base;
        end else if (dir_left) begin
            c_sel = single ? {c_base[26:0], c_base[27]} : {c_base[25:0], c_base[27:26]};
            d_sel = single ? {d_base[26:0], d_base[27]} : {d_base[25:0], d_base[27:26]};
        end else begin
            c_sel = single ? {c_base[0], c_base[27:1]} : {c_base[1:0], c_base[27:2]};
            d_sel = single ? {d_base[0], d_base[27:1]} : {d_base[1:0], d_base[27:2]};
        end
        cd_sel = {c_sel, d_sel};
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        dec_d   = dec_q;
        idx_d   = idx_q;
        rk_d    = rk_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ROUND;
                    c_d     = c_sel;
                    d_d     = d_sel;
                    dec_d   = decrypt;
                    idx_d   = 4'd0;
                    rk_d    = pc2_out;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef DES_KEY_PARITY_CHECK_EN
                    parity_d = |byte_even;
`endif
                end
            end
            S_ROUND: begin
                if (valid_q && round_key_ready) begin
                    if (idx_q == 4'd15) begin
                        state_d = S_DONE;
                        rk_d    = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        c_d   = c_sel;
                        d_d   = d_sel;
                        idx_d = idx_next;
                        rk_d  = pc2_out;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            dec_q   <= 1'b0;
            idx_q   <= '0;
            rk_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dec_q   <= dec_d;
            idx_q   <= idx_d;
            rk_q    <= rk_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DES_KEY_PARITY_CHECK_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign round_key       = rk_q;
    assign round_key_valid = valid_q;
    assign round_idx       = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;
`ifdef DES_KEY_PARITY_CHECK_EN
    assign parity_err      = parity_q;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: a table-driven DES key model fills an expectation queue, a negedge monitor drains it.
module tb_des_key_schedule;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct {
        logic [47:0] key;
        logic [3:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] key_in = '0;
    logic        decrypt = 1'b0;
    logic [47:0] round_key;
    logic        round_key_valid;
    logic        round_key_ready = 1'b0;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic        parity_err;
`endif

    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    bit          rand_ready = 1'b0;
    exp_t        exp_q[$];
    logic [47:0] captured [16];

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .key_in          (key_in),
        .decrypt         (decrypt),
        .round_key       (round_key),
        .round_key_valid (round_key_valid),
        .round_key_ready (round_key_ready),
        .round_idx       (round_idx),
        .busy            (busy),
        .done            (done)
`ifdef DES_KEY_PARITY_CHECK_EN
        ,
        .parity_err      (parity_err)
`endif
    );

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int k);
        logic [55:0] t;
        t = {x, x} << k;
        return t[55:28];
    endfunction

    // Encrypt key K_n is PC2 of C0/D0 rotated by the cumulative shift; decrypt emission n is K_(17-n).
    function automatic logic [47:0] model_key(input logic [63:0] key, input bit dec, input int n);
        logic [55:0] cd;
        logic [55:0] cdn;
        logic [47:0] r;
        int kn;
        int total;
        kn = dec ? 17 - n : n;
        total = 0;
        for (int i = 0; i < kn; i++) total += SHIFTS[i];
        for (int j = 0; j < 56; j++) cd[55-j] = key[64-PC1[j]];
        cdn = {rotl28(cd[55:28], total), rotl28(cd[27:0], total)};
        for (int j = 0; j < 48; j++) r[47-j] = cdn[56-PC2[j]];
        return r;
    endfunction

    function automatic bit model_parity(input logic [63:0] key);
        bit e;
        e = 1'b0;
        for (int b = 0; b < 8; b++) if (^key[8*b +: 8] == 1'b0) e = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [63:0] key, input bit dec);
        for (int n = 1; n <= 16; n++) begin
            exp_t e;
            e.key = model_key(key, dec, n);
            e.idx = 4'(n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!done && cycles < 500);
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    // inject: 0 plain, 1 foreign start at idx 5, 2 reset at idx 7 (schedule aborted)
    task automatic run_schedule(input logic [63:0] key, input bit dec, input bit rr,
                                input int inject, output int cycles);
        int hs0;
        int w;
        cycles = 0;
        w = 0;
        while ((busy || done) && w < 50) begin
            tick();
            w++;
        end
        check("idle_before_start", {62'd0, busy, done}, 64'd0);
        rand_ready = rr;
        push_expected(key, dec);
        hs0 = hs_count;
        start = 1'b1;
        key_in = key;
        decrypt = dec;
        tick();
        start = 1'b0;
        key_in = {$urandom, $urandom};
        decrypt = ~dec;
        check("latency_valid", {63'd0, round_key_valid}, 64'd1);
        check("first_idx", {60'd0, round_idx}, 64'd0);
        check("busy_after_accept", {63'd0, busy}, 64'd1);
`ifdef DES_KEY_PARITY_CHECK_EN
        check("parity_err", {63'd0, parity_err}, {63'd0, model_parity(key)});
`endif
        if (inject != 0) begin
            w = 0;
            while (!(round_key_valid && round_idx == (inject == 1 ? 4'd5 : 4'd7)) && w < 100) begin
                tick();
                w++;
            end
            check("reach_inject_idx", {63'd0, round_key_valid}, 64'd1);
            if (inject == 1) begin
                start = 1'b1;
                key_in = ~key;
                decrypt = ~dec;
                tick();
                start = 1'b0;
                check("busy_after_ignored_start", {63'd0, busy}, 64'd1);
            end else begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("abort_valid", {63'd0, round_key_valid}, 64'd0);
                check("abort_key", {16'd0, round_key}, 64'd0);
                check("abort_idx", {60'd0, round_idx}, 64'd0);
                check("abort_busy_done", {62'd0, busy, done}, 64'd0);
                exp_q.delete();
                repeat (4) tick();
                rand_ready = 1'b0;
                return;
            end
        end
        wait_done(cycles);
        check("handshakes", 64'(hs_count - hs0), 64'd16);
        check("busy_in_done", {63'd0, busy}, 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef DES_KEY_PARITY_CHECK_EN
        check("parity_err_hold", {63'd0, parity_err}, {63'd0, model_parity(key)});
`endif
        rand_ready = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            round_key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: done expectation, zero key while invalid, stall stability, scoreboard pops.
    initial begin
        bit          exp_done;
        bit          stall;
        logic [47:0] s_key;
        logic [3:0]  s_idx;
        exp_t        e;
        exp_done = 1'b0;
        stall = 1'b0;
        s_key = '0;
        s_idx = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_done = 1'b0;
                stall = 1'b0;
            end else begin
                check("done_pulse", {63'd0, done}, {63'd0, exp_done});
                exp_done = 1'b0;
                if (!round_key_valid) check("key_zero_when_invalid", {16'd0, round_key}, 64'd0);
                if (stall) begin
                    check("stall_valid", {63'd0, round_key_valid}, 64'd1);
                    check("stall_key", {16'd0, round_key}, {16'd0, s_key});
                    check("stall_idx", {60'd0, round_idx}, {60'd0, s_idx});
                end
                if (round_key_valid && round_key_ready) begin
                    hs_count++;
                    captured[round_idx] = round_key;
                    if (exp_q.size() == 0) begin
                        check("unexpected_handshake", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("round_key", {16'd0, round_key}, {16'd0, e.key});
                        check("round_idx", {60'd0, round_idx}, {60'd0, e.idx});
                        $display("handshake idx=%0d key=%012h expected=%012h", round_idx, round_key, e.key);
                    end
                    exp_done = (round_idx == 4'd15);
                end
                stall = round_key_valid && !round_key_ready;
                s_key = round_key;
                s_idx = round_idx;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) tick();
        check("reset_valid", {63'd0, round_key_valid}, 64'd0);
        check("reset_key", {16'd0, round_key}, 64'd0);
        check("reset_idx", {60'd0, round_idx}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        rst = 1'b0;
        tick();

        run_schedule(KEY_A, 1'b0, 1'b0, 0, cyc);
        check("back_to_back_cycles", 64'(cyc), 64'd16);
        check("enc_k0", {16'd0, captured[0]}, 64'h1B02EFFC7072);
        check("enc_k1", {16'd0, captured[1]}, 64'h79AED9DBC9E5);
        check("enc_k15", {16'd0, captured[15]}, 64'hCB3D8B0E17F5);

        run_schedule(KEY_A, 1'b1, 1'b0, 0, cyc);
        check("dec_k0", {16'd0, captured[0]}, 64'hCB3D8B0E17F5);
        check("dec_k15", {16'd0, captured[15]}, 64'h1B02EFFC7072);

        run_schedule(KEY_A, 1'b0, 1'b1, 0, cyc);
        for (int i = 0; i < 4; i++)
            run_schedule({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 0, cyc);

        run_schedule(KEY_A, 1'b0, 1'b0, 1, cyc);

        run_schedule(KEY_A, 1'b0, 1'b0, 2, cyc);
        run_schedule(KEY_A, 1'b0, 1'b0, 0, cyc);
        check("after_abort_k0", {16'd0, captured[0]}, 64'h1B02EFFC7072);

        // Start held through DONE: ignored there, accepted in the following IDLE cycle.
        start = 1'b1;
        key_in = 64'h0123456789ABCDEF;
        decrypt = 1'b1;
        tick();
        check("start_in_done_ignored", {62'd0, busy, round_key_valid}, 64'd0);
        push_expected(64'h0123456789ABCDEF, 1'b1);
        tick();
        start = 1'b0;
        check("start_after_done", {62'd0, busy, round_key_valid}, 64'd3);
        wait_done(cyc);
        check("queue_drained_restart", 64'(exp_q.size()), 64'd0);

`ifdef DES_KEY_PARITY_CHECK_EN
        run_schedule(64'h133457799BBCDFF0, 1'b0, 1'b1, 0, cyc);
        run_schedule(KEY_A, 1'b0, 1'b0, 0, cyc);
`endif
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 The block SHALL have no parameters; the round count is fixed at 16.
REQ-002 clk  in  1  Sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  Reset, synchronous, active-high.
REQ-004 start  in  1  Request a new schedule; accepted only when busy=0.
REQ-005 key_in  in  64  DES key; key_in[63] is DES bit 1; sampled on the accepting edge only.
REQ-006 decrypt  in  1  Sampled with start; 0 = emit K1..K16, 1 = emit K16..K1.
REQ-007 round_key  out  48  Current subkey; round_key[47] is PC-2 output bit 1; feeds the Feistel function's round_key input directly.
REQ-008 round_key_valid  out  1  round_key and round_idx are valid.
REQ-009 round_key_ready  in  1  Consumer accepts the current subkey when it is high together with round_key_valid.
REQ-010 round_idx  out  4  Emission index, 0..15 (0 = first key emitted).
REQ-011 busy  out  1  High from the accepting edge until the final handshake.
REQ-012 done  out  1  One-cycle pulse after the 16th handshake.

Function
REQ-013 States SHALL be IDLE, ROUND, and DONE.
REQ-014 IDLE->ROUND SHALL occur on start=1. At the same edge: PC-1(key_in) loads into C (28 b) and D (28 b), decrypt is latched, and round_idx is set to 0.
REQ-015 round_key_valid SHALL rise in the cycle after acceptance (latency 1); round_key SHALL be a registered output.
REQ-016 Encrypt: emission n (n=1..16) SHALL be PC-2(C_n,D_n). C_n and D_n are C_{n-1} and D_{n-1} rotated left by 1 for n in {1,2,9,16}, and by 2 otherwise.
REQ-017 Decrypt: emission n SHALL equal encrypt key K_{17-n}. This is obtained by right rotation from C0/D0: no shift for n=1, 1 for n in {2,9,16}, 2 otherwise.
REQ-018 round_key, round_idx and round_key_valid SHALL hold stable while round_key_valid=1 and round_key_ready=0.
REQ-019 On a valid&&ready handshake with round_idx<15: the next key and round_idx+1 SHALL appear in the next cycle, and round_key_valid SHALL stay high. Back-to-back handshakes SHALL give 1 key per cycle.
REQ-020 On a handshake with round_idx=15: the next state SHALL be DONE, round_key_valid SHALL drop, and busy SHALL drop.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 start while busy=1 or in DONE SHALL be ignored and SHALL NOT alter C, D, the latched decrypt value or round_idx.
REQ-023 Start SHALL be accepted again in the first IDLE cycle following DONE.
REQ-024 round_key_ready while round_key_valid=0 SHALL have no effect.
REQ-025 round_key SHALL be 0 whenever round_key_valid=0.

Reset
REQ-026 rst=1 SHALL force IDLE and clear C, D, round_key, round_idx, round_key_valid, busy and done to 0 at the next rising edge.
REQ-027 rst SHALL override start and any handshake in the same cycle.
REQ-028 rst mid-schedule SHALL abort the schedule with no done pulse.

Configuration
REQ-029 With macro DES_KEY_PARITY_CHECK_EN defined, the block SHALL add an output parity_err (1 bit).
REQ-030 parity_err SHALL register 1 at acceptance if any key_in byte has even parity. It SHALL hold until the next acceptance or rst.
REQ-031 The schedule SHALL proceed normally regardless of parity_err.
REQ-032 Without DES_KEY_PARITY_CHECK_EN, the parity_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Encrypt schedule: key_in=0x133457799BBCDFF1, decrypt=0, ready held 1 -> keys on 16 consecutive cycles. Emission 0=0x1B02EFFC7072, 1=0x79AED9DBC9E5, 15=0xCB3D8B0E17F5. done pulses in the cycle after the last handshake.
REQ-034 Decrypt schedule: same key, decrypt=1 -> emission 0=0xCB3D8B0E17F5, emission 15=0x1B02EFFC7072.
REQ-035 Backpressure: ready toggled 0/1 pseudo-randomly -> the same 16 keys in order; outputs stable during every stall; exactly 16 handshakes.
REQ-036 Start during busy: start=1 with a different key at round_idx=5 -> ignored; remaining keys unchanged; busy stays 1.
REQ-037 Reset mid-operation: rst pulsed at round_idx=7 -> all outputs 0 next cycle and no done. A new start then yields the full sequence from emission 0.
REQ-038 Parity (macro defined): key 0x133457799BBCDFF1 -> parity_err=0; key 0x133457799BBCDFF0 -> parity_err=1, and its schedule still completes.
